// File: rtl/wtm_resetpulsegen.sv
// Reset-request generator: merges a debounced button, a software pulse and a
// watchdog timeout into one stretched, registered active-low reset request.
module wtm_resetpulsegen #(
    parameter int clk_freq_hz    = 10000000,
    parameter int debounce_us    = 5000,
    parameter int pulse_us       = 100,
    parameter int holdoff_us     = 1000,
    parameter int wdt_timeout_us = 1000000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       sw_req,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       rst_req_n,
    output logic [1:0] cause,
    output logic       busy
);

    function automatic int at_least_one(input int value);
        return (value < 1) ? 1 : value;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CYC_PER_US = clk_freq_hz / 1000000;
    localparam int DEB_CYC    = at_least_one(debounce_us * CYC_PER_US);
    localparam int PULSE_CYC  = at_least_one(pulse_us * CYC_PER_US);
    localparam int HOLD_CYC   = at_least_one(holdoff_us * CYC_PER_US);
    localparam int WDT_CYC    = at_least_one(wdt_timeout_us * CYC_PER_US);
    localparam int MAX_CYC    = max_of(max_of(DEB_CYC, PULSE_CYC), max_of(HOLD_CYC, WDT_CYC));
    localparam int CW         = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] WDT_LAST   = CW'(WDT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLDOFF
    } state_t;

    state_t        state;
    logic          btn_sync1;
    logic          btn_sync2;
    logic          btn_deb;
    logic [CW-1:0] deb_cnt;
    logic          btn_evt;
    logic [CW-1:0] wdt_cnt;
    logic          wdt_evt;
    logic [CW-1:0] pulse_cnt;

    // The button is asynchronous, so it passes two flops before the debouncer
    // sees it; only a press (high-to-low on the debounced level) is an event.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            btn_sync1 <= 1'b1;
            btn_sync2 <= 1'b1;
            btn_deb   <= 1'b1;
            deb_cnt   <= '0;
            btn_evt   <= 1'b0;
        end else begin
            btn_sync1 <= btn_n;
            btn_sync2 <= btn_sync1;
            btn_evt   <= 1'b0;
            if (btn_sync2 == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt <= '0;
                btn_deb <= btn_sync2;
                btn_evt <= btn_deb;
            end else begin
                deb_cnt <= deb_cnt + CNT_ONE;
            end
        end
    end

    // The kick is tested before the terminal count so a simultaneous kick wins.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wdt_cnt <= '0;
            wdt_evt <= 1'b0;
        end else begin
            wdt_evt <= 1'b0;
            if (!wdt_en || wdt_kick || busy) begin
                wdt_cnt <= '0;
            end else if (wdt_cnt == WDT_LAST) begin
                wdt_cnt <= '0;
                wdt_evt <= 1'b1;
            end else begin
                wdt_cnt <= wdt_cnt + CNT_ONE;
            end
        end
    end

    // Requests are only looked at in IDLE; anything arriving while busy is lost.
    // HOLDOFF also waits for the button to be released so a held button
    // cannot retrigger.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rst_req_n <= 1'b1;
            cause     <= 2'b00;
            busy      <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_evt || wdt_evt || sw_req) begin
                        state     <= PULSE;
                        rst_req_n <= 1'b0;
                        busy      <= 1'b1;
                        pulse_cnt <= '0;
                        if (btn_evt) begin
                            cause <= 2'b01;
                        end else if (wdt_evt) begin
                            cause <= 2'b10;
                        end else begin
                            cause <= 2'b11;
                        end
                    end
                end
                PULSE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state     <= HOLDOFF;
                        rst_req_n <= 1'b1;
                        pulse_cnt <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + CNT_ONE;
                    end
                end
                HOLDOFF: begin
                    if (pulse_cnt == HOLD_LAST) begin
                        if (btn_deb) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            pulse_cnt <= '0;
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rst_req_n <= 1'b1;
                    busy      <= 1'b0;
                    pulse_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wtm_resetpulsegen.sv
// Bench for wtm_resetpulsegen: timestamp-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_wtm_resetpulsegen;

    localparam int P   = 8;
    localparam int H   = 6;
    localparam int DEB = 4;
    localparam int WDT = 20;

    logic       clock = 1'b0;
    logic       rst;
    logic       btn_n = 1'b1;
    logic       sw_req = 1'b0;
    logic       wdt_en = 1'b0;
    logic       wdt_kick = 1'b0;
    logic       rst_req_n;
    logic [1:0] cause;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int p0;

    wtm_resetpulsegen #(
        .clk_freq_hz   (1000000),
        .debounce_us   (4),
        .pulse_us      (8),
        .holdoff_us    (6),
        .wdt_timeout_us(20)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .btn_n    (btn_n),
        .sw_req   (sw_req),
        .wdt_en   (wdt_en),
        .wdt_kick (wdt_kick),
        .rst_req_n(rst_req_n),
        .cause    (cause),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    always @(negedge rst_req_n) pulses++;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: edges are numbered, and the pulse is described by the edge
    // that started it rather than by a state machine.
    int         m_edge = 0;
    int         m_start = 0;
    int         m_wdt_clear = 0;
    int         m_streak = 1;
    logic       m_h1 = 1'b1;
    logic       m_h2 = 1'b1;
    logic       m_deb = 1'b1;
    logic       m_btn_evt = 1'b0;
    logic       m_wdt_evt = 1'b0;
    logic       m_active = 1'b0;
    logic [1:0] m_cause = 2'b00;
    logic       m_rstn = 1'b1;
    bit         m_valid = 1'b0;

    always @(posedge clock or posedge rst) begin : model
        logic s2, deb_pre, bevt_pre, wevt_pre, busy_pre;
        int   e;
        if (rst) begin
            m_edge = 0; m_start = 0; m_wdt_clear = 0; m_streak = 1;
            m_h1 = 1'b1; m_h2 = 1'b1; m_deb = 1'b1;
            m_btn_evt = 1'b0; m_wdt_evt = 1'b0; m_active = 1'b0;
            m_cause = 2'b00; m_rstn = 1'b1; m_valid = 1'b1;
        end else begin
            s2 = m_h2; deb_pre = m_deb; bevt_pre = m_btn_evt;
            wevt_pre = m_wdt_evt; busy_pre = m_active;
            m_edge++;
            e = m_edge;
            if (!m_active) begin
                if (bevt_pre || wevt_pre || sw_req) begin
                    m_active = 1'b1;
                    m_start  = e;
                    m_cause  = bevt_pre ? 2'b01 : (wevt_pre ? 2'b10 : 2'b11);
                end
            end else if ((e - m_start) >= P + H && deb_pre) begin
                m_active = 1'b0;
            end
            m_rstn = !(m_active && (e - m_start) < P);
            m_wdt_evt = 1'b0;
            if (!wdt_en || wdt_kick || busy_pre) begin
                m_wdt_clear = e;
            end else if (e - m_wdt_clear == WDT) begin
                m_wdt_evt = 1'b1;
                m_wdt_clear = e;
            end
            m_btn_evt = 1'b0;
            if (s2 == deb_pre) begin
                m_streak = e + 1;
            end else if (e - m_streak + 1 == DEB) begin
                m_deb = ~deb_pre;
                m_streak = e + 1;
                m_btn_evt = deb_pre;
            end
            m_h2 = m_h1;
            m_h1 = btn_n;
        end
    end

    always @(negedge clock) begin
        if (!rst && m_valid) begin
            check_output("model rst_req_n", {31'd0, rst_req_n}, {31'd0, m_rstn});
            check_output("model cause", {30'd0, cause}, {30'd0, m_cause});
            check_output("model busy", {31'd0, busy}, {31'd0, m_active});
        end
    end

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        check_output("idle within budget", {31'd0, busy}, 32'd0);
    endtask

    task automatic apply_stimulus(input int cycles);
        repeat (cycles) @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global timeout reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b0;
        #2 rst = 1'b1;
        apply_stimulus(3);
        check_output("reset rst_req_n", {31'd0, rst_req_n}, 32'd1);
        check_output("reset cause", {30'd0, cause}, 32'd0);
        check_output("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        apply_stimulus(5);

        // Software request: low for 8 cycles, busy for 14.
        sw_req = 1'b1;
        apply_stimulus(1);
        sw_req = 1'b0;
        check_output("sw first low cycle", {31'd0, rst_req_n}, 32'd0);
        check_output("sw cause", {30'd0, cause}, 32'd3);
        check_output("sw busy", {31'd0, busy}, 32'd1);
        apply_stimulus(7);
        check_output("sw last low cycle", {31'd0, rst_req_n}, 32'd0);
        apply_stimulus(1);
        check_output("sw released", {31'd0, rst_req_n}, 32'd1);
        check_output("sw holdoff busy", {31'd0, busy}, 32'd1);
        apply_stimulus(5);
        check_output("sw last holdoff", {31'd0, busy}, 32'd1);
        apply_stimulus(1);
        check_output("sw idle again", {31'd0, busy}, 32'd0);

        // Glitchy button, then a held press.
        p0 = pulses;
        repeat (4) begin
            btn_n = 1'b0;
            apply_stimulus(2);
            btn_n = 1'b1;
            apply_stimulus(1);
        end
        apply_stimulus(4);
        check_output("glitches no pulse", pulses, p0);
        btn_n = 1'b0;
        apply_stimulus(6);
        check_output("btn before latency", {31'd0, rst_req_n}, 32'd1);
        apply_stimulus(1);
        check_output("btn pulse start", {31'd0, rst_req_n}, 32'd0);
        check_output("btn cause", {30'd0, cause}, 32'd1);
        apply_stimulus(43);
        check_output("held btn still busy", {31'd0, busy}, 32'd1);
        btn_n = 1'b1;
        wait_idle(40);
        check_output("held btn one pulse", pulses, p0 + 1);

        // Watchdog timeout, then regular kicking.
        wdt_en = 1'b1;
        apply_stimulus(20);
        check_output("wdt before timeout", {31'd0, rst_req_n}, 32'd1);
        apply_stimulus(1);
        check_output("wdt pulse start", {31'd0, rst_req_n}, 32'd0);
        check_output("wdt cause", {30'd0, cause}, 32'd2);
        p0 = pulses;
        for (int i = 0; i < 200; i++) begin
            wdt_kick = (i % 15 == 0);
            apply_stimulus(1);
        end
        wdt_kick = 1'b0;
        wdt_en = 1'b0;
        check_output("kicked wdt no pulse", pulses, p0);
        wait_idle(20);

        // Button and software in the same cycle; second sw_req in HOLDOFF.
        btn_n = 1'b0;
        apply_stimulus(6);
        sw_req = 1'b1;
        apply_stimulus(1);
        sw_req = 1'b0;
        btn_n = 1'b1;
        check_output("coincident pulse", {31'd0, rst_req_n}, 32'd0);
        check_output("coincident cause", {30'd0, cause}, 32'd1);
        p0 = pulses;
        apply_stimulus(10);
        sw_req = 1'b1;
        apply_stimulus(1);
        sw_req = 1'b0;
        check_output("holdoff sw ignored", {31'd0, rst_req_n}, 32'd1);
        wait_idle(30);
        apply_stimulus(3);
        check_output("holdoff no second pulse", pulses, p0);
        check_output("cause kept", {30'd0, cause}, 32'd1);

        // Reset in the middle of a pulse.
        sw_req = 1'b1;
        apply_stimulus(1);
        sw_req = 1'b0;
        apply_stimulus(3);
        check_output("pre-reset low", {31'd0, rst_req_n}, 32'd0);
        rst = 1'b1;
        #1;
        check_output("async reset rst_req_n", {31'd0, rst_req_n}, 32'd1);
        check_output("async reset cause", {30'd0, cause}, 32'd0);
        check_output("async reset busy", {31'd0, busy}, 32'd0);
        apply_stimulus(1);
        rst = 1'b0;
        apply_stimulus(1);
        sw_req = 1'b1;
        apply_stimulus(1);
        sw_req = 1'b0;
        check_output("post-reset pulse", {31'd0, rst_req_n}, 32'd0);
        apply_stimulus(7);
        check_output("post-reset last low", {31'd0, rst_req_n}, 32'd0);
        apply_stimulus(1);
        check_output("post-reset released", {31'd0, rst_req_n}, 32'd1);
        wait_idle(20);

        // Kick coincident with the timeout cycle.
        apply_stimulus(2);
        wdt_en = 1'b1;
        apply_stimulus(19);
        wdt_kick = 1'b1;
        apply_stimulus(1);
        wdt_kick = 1'b0;
        check_output("kick at timeout", {31'd0, rst_req_n}, 32'd1);
        apply_stimulus(1);
        check_output("kick wins no pulse", {31'd0, rst_req_n}, 32'd1);
        apply_stimulus(19);
        check_output("restarted before timeout", {31'd0, rst_req_n}, 32'd1);
        apply_stimulus(1);
        check_output("restarted timeout pulse", {31'd0, rst_req_n}, 32'd0);
        check_output("restarted cause", {30'd0, cause}, 32'd2);
        wdt_en = 1'b0;
        wait_idle(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
